// File: rtl/lmsm_sequencer_if.sv
// IF/ID-side bundle for the LM/SM expander: instruction in, single-register micro-op out.
interface lmsm_sequencer_if;
    logic [15:0] IF_ID_IR;
    logic        IF_ID_VALID;
    logic        ADV;
    logic        FLUSH;
    logic [15:0] UOP_IR;
    logic        UOP_VALID;
    logic [2:0]  UOP_REG;
    logic [2:0]  UOP_OFFSET;
    logic        UOP_FIRST;
    logic        UOP_LAST;
    logic        IS_LM;
    logic        IS_SM;
    logic        IF_STALL;
    logic        BUSY;

    modport master (
        output IF_ID_IR, IF_ID_VALID, ADV, FLUSH,
        input  UOP_IR, UOP_VALID, UOP_REG, UOP_OFFSET, UOP_FIRST, UOP_LAST,
               IS_LM, IS_SM, IF_STALL, BUSY
    );

    modport slave (
        input  IF_ID_IR, IF_ID_VALID, ADV, FLUSH,
        output UOP_IR, UOP_VALID, UOP_REG, UOP_OFFSET, UOP_FIRST, UOP_LAST,
               IS_LM, IS_SM, IF_STALL, BUSY
    );
endinterface

// File: rtl/lmsm_sequencer.sv
// Expands LM/SM instructions into one micro-op per set mask bit (highest bit first);
// all other instructions pass straight through to ID/RR.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | pass-through; an LM/SM here emits its first (or only) micro-op
// S_EXPAND | serving the remaining bits of the held LM/SM, fetch stalled
module lmsm_sequencer (
    input  logic              CLK,
    input  logic              RST_N,
    lmsm_sequencer_if.slave   bus
);
    localparam logic [3:0] OPC_LM   = 4'b0110;
    localparam logic [3:0] OPC_SM   = 4'b0111;
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_EXPAND = 1'b1;

    logic [0:0]  r_state;
    logic [7:0]  r_mask;
    logic [15:0] r_ir;
    logic [2:0]  r_off;

    logic        w_busy;
    logic [15:0] w_ir;
    logic [7:0]  w_mask;
    logic        w_is_lm;
    logic        w_is_sm;
    logic        w_lmsm;
    logic [2:0]  w_pos;
    logic [7:0]  w_hit;
    logic [7:0]  w_rest;
    logic        w_multi;
    logic        w_any;

    assign w_busy  = (r_state == S_EXPAND);
    assign w_ir    = w_busy ? r_ir   : bus.IF_ID_IR;
    assign w_mask  = w_busy ? r_mask : bus.IF_ID_IR[7:0];
    assign w_is_lm = (w_ir[15:12] == OPC_LM);
    assign w_is_sm = (w_ir[15:12] == OPC_SM);
    assign w_lmsm  = w_busy || (bus.IF_ID_VALID && (w_is_lm || w_is_sm));

    // Ascending scan so the highest set bit wins.
    always_comb begin
        w_pos = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_mask[i]) w_pos = i[2:0];
        end
    end

    assign w_hit   = 8'b0000_0001 << w_pos;
    assign w_rest  = w_mask & ~w_hit;
    assign w_multi = |w_rest;
    assign w_any   = |w_mask;

    logic [15:0] w_uop_ir;
    logic        w_uop_valid;
    logic [2:0]  w_uop_reg;
    logic [2:0]  w_uop_off;
    logic        w_uop_first;
    logic        w_uop_last;
    logic        w_out_lm;
    logic        w_out_sm;
    logic        w_stall;
    logic        w_out_busy;

    always_comb begin
        w_uop_ir    = 16'h0000;
        w_uop_valid = 1'b0;
        w_uop_reg   = 3'd0;
        w_uop_off   = 3'd0;
        w_uop_first = 1'b0;
        w_uop_last  = 1'b0;
        w_out_lm    = 1'b0;
        w_out_sm    = 1'b0;
        w_stall     = 1'b0;
        w_out_busy  = 1'b0;
        if (RST_N) begin
            if (!w_lmsm) begin
                w_uop_ir    = bus.IF_ID_IR;
                w_uop_valid = bus.IF_ID_VALID;
            end else if (w_any) begin
                w_uop_ir    = {w_ir[15:9], 1'b0, w_hit};
                w_uop_valid = 1'b1;
                w_uop_reg   = 3'd7 - w_pos;
                w_uop_off   = w_busy ? r_off : 3'd0;
                w_uop_first = !w_busy;
                w_uop_last  = !w_multi;
                w_out_lm    = w_is_lm;
                w_out_sm    = w_is_sm;
                w_stall     = w_multi;
            end
            if (bus.FLUSH) begin
                w_uop_valid = 1'b0;
                w_stall     = 1'b0;
            end
            w_out_busy = w_busy;
        end
    end

    assign bus.UOP_IR     = w_uop_ir;
    assign bus.UOP_VALID  = w_uop_valid;
    assign bus.UOP_REG    = w_uop_reg;
    assign bus.UOP_OFFSET = w_uop_off;
    assign bus.UOP_FIRST  = w_uop_first;
    assign bus.UOP_LAST   = w_uop_last;
    assign bus.IS_LM      = w_out_lm;
    assign bus.IS_SM      = w_out_sm;
    assign bus.IF_STALL   = w_stall;
    assign bus.BUSY       = w_out_busy;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_mask  <= 8'h00;
            r_ir    <= 16'h0000;
            r_off   <= 3'd0;
        end else if (bus.FLUSH) begin
            r_state <= S_IDLE;
            r_mask  <= 8'h00;
            r_off   <= 3'd0;
        end else if (bus.ADV) begin
            case (r_state)
                S_IDLE: begin
                    if (w_lmsm && w_multi) begin
                        r_ir    <= bus.IF_ID_IR;
                        r_mask  <= w_rest;
                        r_off   <= 3'd1;
                        r_state <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    if (w_multi) begin
                        r_mask <= w_rest;
                        r_off  <= r_off + 3'd1;
                    end else begin
                        r_mask  <= 8'h00;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
